// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Driving end of the CPU run/halt interface. The controller holds the CPU in
// reset until a start request arrives. It then releases the CPU and counts
// run cycles. The run stops when the CPU halts or when the cycle budget runs
// out. One settle cycle follows, after which pc and x3 are captured and the
// outcome is offered to the host over a valid/ready handshake.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : synchronous active-high reset
//   start          : run request, looked at only while idle
//   cpu_halt       : CPU halt indication, looked at only while running
//   cpu_pc/cpu_x3  : CPU program counter and register x3
//   cpu_reset      : reset to the CPU (high in IDLE and RST)
//   cpu_run        : clock enable to the CPU (high only in RUN)
//   busy           : high in every state except IDLE
//   result_valid   : result on offer (REPORT)
//   result_ready   : host accepts the result
//   result_halted  : the run ended because of cpu_halt
//   result_timeout : the run ended because the budget ran out
//   result_cycles  : number of run cycles consumed
//   result_pc/x3   : pc and x3 captured at the end of the settle cycle
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CW         = 32,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            cpu_halt,
  input  logic [XLEN-1:0] cpu_pc,
  input  logic [XLEN-1:0] cpu_x3,
  output logic            cpu_reset,
  output logic            cpu_run,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            result_halted,
  output logic            result_timeout,
  output logic [CW-1:0]   result_cycles,
  output logic [XLEN-1:0] result_pc,
  output logic [XLEN-1:0] result_x3
);

  // The reset counter only has to reach RST_CYCLES-1.
  localparam int unsigned   RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CYC_MAX  = CW'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]     run_cnt_q, run_cnt_d;
  logic [CW-1:0]     run_inc_s;
  logic              cpu_reset_q, cpu_reset_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic [CW-1:0]     cycles_q, cycles_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   x3_q, x3_d;

  // Next-state, counter and result-capture logic.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    run_cnt_d = run_cnt_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    cycles_d  = cycles_q;
    pc_d      = pc_q;
    x3_d      = x3_q;
    // The count that the current RUN cycle ends with.
    run_inc_s = run_cnt_q + {{(CW-1){1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RST;
          rst_cnt_d = {RW{1'b0}};
          run_cnt_d = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + {{(RW-1){1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        run_cnt_d = run_inc_s;
        // Halt takes priority over the budget when both land on the same edge.
        if (cpu_halt) begin
          state_d   = S_DRAIN;
          halted_d  = 1'b1;
          timeout_d = 1'b0;
          cycles_d  = run_inc_s;
        end else if (run_inc_s == CYC_MAX) begin
          state_d   = S_DRAIN;
          halted_d  = 1'b0;
          timeout_d = 1'b1;
          cycles_d  = CYC_MAX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // The CPU is frozen for this cycle, so its writeback has settled by the capture edge.
        state_d = S_REPORT;
        pc_d    = cpu_pc;
        x3_d    = cpu_x3;
      end
      S_REPORT: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REPORT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming state, so every output leaves a flop.
  always_comb begin
    cpu_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
    cpu_run_d   = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    valid_d     = (state_d == S_REPORT);
  end

  // State, counters, outputs and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= {RW{1'b0}};
      run_cnt_q   <= {CW{1'b0}};
      cpu_reset_q <= 1'b1;
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cycles_q    <= {CW{1'b0}};
      pc_q        <= {XLEN{1'b0}};
      x3_q        <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      run_cnt_q   <= run_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_run_q   <= cpu_run_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      cycles_q    <= cycles_d;
      pc_q        <= pc_d;
      x3_q        <= x3_d;
    end
  end

  assign cpu_reset      = cpu_reset_q;
  assign cpu_run        = cpu_run_q;
  assign busy           = busy_q;
  assign result_valid   = valid_q;
  assign result_halted  = halted_q;
  assign result_timeout = timeout_q;
  assign result_cycles  = cycles_q;
  assign result_pc      = pc_q;
  assign result_x3      = x3_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// This bench runs directed scenarios and then randomized traffic against
// cpu_run_ctrl. The reference model describes a run by elapsed time since
// start, t, and by the final run length, end. The CPU is in reset while
// t < RST. It runs while the end is not yet known. The single cycle with
// t == RST+end is the settle cycle, and every later cycle is reporting.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int MAXC = 20;
  localparam int RSTC = 4;

  logic        clk = 1'b0;
  logic        reset, start, cpu_halt, result_ready;
  logic [31:0] cpu_pc, cpu_x3;
  logic        cpu_reset, cpu_run, busy, result_valid;
  logic        result_halted, result_timeout;
  logic [31:0] result_cycles, result_pc, result_x3;

  cpu_run_ctrl #(.MAX_CYCLES(MAXC), .RST_CYCLES(RSTC), .CW(32), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(cpu_halt),
    .cpu_pc(cpu_pc), .cpu_x3(cpu_x3), .cpu_reset(cpu_reset), .cpu_run(cpu_run),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_halted(result_halted), .result_timeout(result_timeout),
    .result_cycles(result_cycles), .result_pc(result_pc), .result_x3(result_x3)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_active  = 1'b0;
  int          m_t       = 0;
  int          m_end     = -1;
  bit          m_valid   = 1'b0;
  bit          m_halted  = 1'b0;
  bit          m_timeout = 1'b0;
  int          m_cycles  = 0;
  logic [31:0] m_pc      = 32'd0;
  logic [31:0] m_x3      = 32'd0;
  int          m_results = 0;
  int          hs_cnt    = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0; m_valid <= 1'b0; m_halted <= 1'b0; m_timeout <= 1'b0;
      m_cycles <= 0; m_pc <= 32'd0; m_x3 <= 32'd0; m_t <= 0; m_end <= -1;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1; m_t <= 0; m_end <= -1;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t >= RSTC && m_end < 0) begin
        if (cpu_halt) begin
          m_end <= m_t - RSTC + 1; m_halted <= 1'b1; m_timeout <= 1'b0;
          m_cycles <= m_t - RSTC + 1;
        end else if (m_t - RSTC + 1 == MAXC) begin
          m_end <= MAXC; m_halted <= 1'b0; m_timeout <= 1'b1; m_cycles <= MAXC;
        end
      end else if (m_end >= 0 && m_t == RSTC + m_end) begin
        m_pc <= cpu_pc; m_x3 <= cpu_x3; m_valid <= 1'b1;
      end else if (m_end >= 0 && m_t > RSTC + m_end && result_ready) begin
        m_active <= 1'b0; m_valid <= 1'b0; m_results <= m_results + 1;
      end
    end
  end

  // Handshakes the DUT actually completed.
  always @(posedge clk) begin
    if (!reset && result_valid && result_ready) hs_cnt <= hs_cnt + 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_reset", cpu_reset, !m_active || m_t < RSTC);
      check("cpu_run", cpu_run, m_active && m_t >= RSTC && m_end < 0);
      check("busy", busy, m_active);
      check("result_valid", result_valid, m_valid);
      check("result_halted", result_halted, m_halted);
      check("result_timeout", result_timeout, m_timeout);
      check("result_cycles", result_cycles, m_cycles);
      check("result_pc", result_pc, m_pc);
      check("result_x3", result_x3, m_x3);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int n_run;

  initial begin
    reset = 1'b1; start = 1'b0; cpu_halt = 1'b0; result_ready = 1'b0;
    cpu_pc = 32'd0; cpu_x3 = 32'd0;
    cyc(); cyc();
    chk_en = 1'b1;
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_cpu_run", cpu_run, 1'b0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_cycles", result_cycles, 32'd0);
    reset = 1'b0;

    // Halt in the 5th run cycle, with ready held low for 3 REPORT cycles.
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    check("t1_reset_held", cpu_reset, 1'b1);
    cyc();
    check("t1_reset_released", cpu_reset, 1'b0);
    check("t1_run1", cpu_run, 1'b1);
    repeat (4) cyc();
    cpu_halt = 1'b1; cpu_pc = 32'h40; cpu_x3 = 32'd7;
    cyc();
    cpu_halt = 1'b0;
    check("t1_drain_valid", result_valid, 1'b0);
    cyc();
    check("t1_valid", result_valid, 1'b1);
    check("t1_halted", result_halted, 1'b1);
    check("t1_timeout", result_timeout, 1'b0);
    check("t1_cycles", result_cycles, 32'd5);
    check("t1_pc", result_pc, 32'h40);
    check("t1_x3", result_x3, 32'd7);
    for (int i = 0; i < 3; i++) begin
      cpu_pc = $urandom; cpu_x3 = $urandom;
      cyc();
      check("t1_hold_valid", result_valid, 1'b1);
      check("t1_hold_pc", result_pc, 32'h40);
      check("t1_hold_x3", result_x3, 32'd7);
    end
    result_ready = 1'b1; cyc(); result_ready = 1'b0;
    check("t1_idle_reset", cpu_reset, 1'b1);
    check("t1_idle_valid", result_valid, 1'b0);
    check("t1_retain_pc", result_pc, 32'h40);

    // Timeout: no halt at all. A start pulse during REPORT must be ignored.
    start = 1'b1; cyc(); start = 1'b0;
    n_run = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (cpu_run) n_run++;
    end
    check("t2_run_cycles", n_run, 20);
    check("t2_timeout", result_timeout, 1'b1);
    check("t2_halted", result_halted, 1'b0);
    check("t2_cycles", result_cycles, 32'd20);
    start = 1'b1; cyc(); start = 1'b0;
    result_ready = 1'b1; cyc(); result_ready = 1'b0;

    // Halt in the last budget cycle. A start pulse during RUN must be ignored.
    start = 1'b1; cyc(); start = 1'b0;
    repeat (RSTC + 5) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (13) cyc();
    cpu_halt = 1'b1; cyc(); cpu_halt = 1'b0;
    cyc();
    check("t3_halted", result_halted, 1'b1);
    check("t3_timeout", result_timeout, 1'b0);
    check("t3_cycles", result_cycles, 32'd20);
    result_ready = 1'b1; cyc(); result_ready = 1'b0;

    // Reset during run cycle 3, then a normal run.
    start = 1'b1; cyc(); start = 1'b0;
    repeat (RSTC + 2) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    check("t4_run", cpu_run, 1'b0);
    check("t4_reset", cpu_reset, 1'b1);
    check("t4_valid", result_valid, 1'b0);
    check("t4_busy", busy, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (RSTC + 1) cyc();
    cpu_halt = 1'b1; cyc(); cpu_halt = 1'b0;
    cyc();
    check("t4_cycles", result_cycles, 32'd2);
    check("t4_halted", result_halted, 1'b1);
    result_ready = 1'b1; cyc(); result_ready = 1'b0;

    // Randomized traffic, including a stretch with start held high.
    for (int i = 0; i < 3000; i++) begin
      start        = (i >= 1000 && i < 1300) ? 1'b1 : ($urandom_range(0, 3) == 0);
      cpu_halt     = ($urandom_range(0, 15) == 0);
      result_ready = $urandom_range(0, 1);
      cpu_pc       = $urandom;
      cpu_x3       = $urandom;
      reset        = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0; start = 1'b0; cpu_halt = 1'b0; result_ready = 1'b1;
    repeat (MAXC + RSTC + 5) cyc();
    check("result_count", hs_cnt, m_results);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
